memory_access_arbiter: RTL and testbench

- Shares the main memory's single request port between two requesters: port 0 (instruction-fetch miss path, read-only) and port 1 (data-cache miss/writeback path, read and write).
- Arbitrates round-robin, issues one request per accepted cycle and tracks outstanding reads by read serial.
- Routes each returning read line to the requester that issued it.
- Sits between the cache-miss handlers and the main memory module.

---
 rtl/memory_access_arbiter.sv | 122 ++++++++++++
 tb/tb_memory_access_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter sharing one memory request port between I-fetch (port 0) and D-cache (port 1),
// tracking outstanding reads by serial so each returning line is routed to its issuer.
module memory_access_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 128,
   parameter int SERIAL_WIDTH    = 4,
   parameter int WSERIAL_WIDTH   = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0Valid,
   input  logic [ADDR_WIDTH-1:0]    req0Addr,
   output logic                     req0Ack,
   output logic                     rsp0Valid,
   output logic [DATA_WIDTH-1:0]    rsp0Data,
   input  logic                     req1Valid,
   input  logic                     req1Write,
   input  logic [ADDR_WIDTH-1:0]    req1Addr,
   input  logic [DATA_WIDTH-1:0]    req1WriteData,
   output logic                     req1Ack,
   output logic                     rsp1Valid,
   output logic [DATA_WIDTH-1:0]    rsp1Data,
   output logic                     wrDoneValid,
   output logic [WSERIAL_WIDTH-1:0] wrDoneSerial,
   output logic [ADDR_WIDTH-1:0]    memAccessAddr,
   output logic [DATA_WIDTH-1:0]    memAccessWriteData,
   output logic                     memAccessRE,
   output logic                     memAccessWE,
   input  logic                     memAccessBusy,
   input  logic                     memReadDataReady,
   input  logic [DATA_WIDTH-1:0]    memReadData,
   input  logic [SERIAL_WIDTH-1:0]  memReadSerial,
   input  logic                     memWriteRespValid,
   input  logic [WSERIAL_WIDTH-1:0] memWriteRespSerial,
   output logic                     routeError
);

   localparam int NSER  = 1 << SERIAL_WIDTH;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic                    last_grant_q, last_grant_d;
   logic [SERIAL_WIDTH-1:0] rd_serial_q, rd_serial_d;
   logic [CNT_W-1:0]        outstanding_q, outstanding_d;
   logic [NSER-1:0]         route_vld_q, route_vld_d;
   logic [NSER-1:0]         route_port_q, route_port_d;
   logic                    route_err_q, route_err_d;

   logic rd_block, elig0, elig1, sel0, sel1, acc_rd, rsp_hit, rsp_miss;

   always_comb begin
      rd_block = (outstanding_q == CNT_W'(MAX_OUTSTANDING));
      elig0    = !rst && req0Valid && !rd_block;
      elig1    = !rst && req1Valid && (req1Write || !rd_block);
      // On a tie, the port that did not win last time goes
      sel1     = elig1 && (!elig0 || !last_grant_q);
      sel0     = elig0 && !sel1;

      memAccessRE        = sel0 || (sel1 && !req1Write);
      memAccessWE        = sel1 && req1Write;
      memAccessAddr      = sel0 ? req0Addr : (sel1 ? req1Addr : '0);
      memAccessWriteData = (sel1 && req1Write) ? req1WriteData : '0;
      req0Ack            = sel0 && !memAccessBusy;
      req1Ack            = sel1 && !memAccessBusy;
      acc_rd             = memAccessRE && !memAccessBusy;

      rsp_hit   = !rst && memReadDataReady && route_vld_q[memReadSerial];
      rsp_miss  = !rst && memReadDataReady && !route_vld_q[memReadSerial];
      rsp0Valid = rsp_hit && !route_port_q[memReadSerial];
      rsp1Valid = rsp_hit && route_port_q[memReadSerial];
      rsp0Data  = memReadData;
      rsp1Data  = memReadData;

      wrDoneValid  = !rst && memWriteRespValid;
      wrDoneSerial = memWriteRespSerial;
      routeError   = route_err_q;
   end

   always_comb begin
      last_grant_d  = last_grant_q;
      rd_serial_d   = rd_serial_q;
      outstanding_d = outstanding_q;
      route_vld_d   = route_vld_q;
      route_port_d  = route_port_q;
      route_err_d   = route_err_q || rsp_miss;

      if (req0Ack) last_grant_d = 1'b0;
      if (req1Ack) last_grant_d = 1'b1;

      if (rsp_hit) route_vld_d[memReadSerial] = 1'b0;
      if (acc_rd) begin
         route_vld_d[rd_serial_q]  = 1'b1;
         route_port_d[rd_serial_q] = sel1;
         rd_serial_d               = rd_serial_q + 1'b1;
      end

      case ({acc_rd, rsp_hit})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q  <= 1'b1;
         rd_serial_q   <= '0;
         outstanding_q <= '0;
         route_vld_q   <= '0;
         route_port_q  <= '0;
         route_err_q   <= 1'b0;
      end else begin
         last_grant_q  <= last_grant_d;
         rd_serial_q   <= rd_serial_d;
         outstanding_q <= outstanding_d;
         route_vld_q   <= route_vld_d;
         route_port_q  <= route_port_d;
         route_err_q   <= route_err_d;
      end
   end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter built with a 2-deep outstanding limit.
module tb_memory_access_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0Valid, req0Ack, rsp0Valid;
   logic [31:0]  req0Addr;
   logic [127:0] rsp0Data;
   logic         req1Valid, req1Write, req1Ack, rsp1Valid;
   logic [31:0]  req1Addr;
   logic [127:0] req1WriteData, rsp1Data;
   logic         wrDoneValid;
   logic [3:0]   wrDoneSerial;
   logic [31:0]  memAccessAddr;
   logic [127:0] memAccessWriteData;
   logic         memAccessRE, memAccessWE, memAccessBusy;
   logic         memReadDataReady;
   logic [127:0] memReadData;
   logic [3:0]   memReadSerial;
   logic         memWriteRespValid;
   logic [3:0]   memWriteRespSerial;
   logic         routeError;

   int checks = 0;
   int errors = 0;

   memory_access_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(128), .SERIAL_WIDTH(4),
      .WSERIAL_WIDTH(4), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Ack(req0Ack),
      .rsp0Valid(rsp0Valid), .rsp0Data(rsp0Data),
      .req1Valid(req1Valid), .req1Write(req1Write), .req1Addr(req1Addr),
      .req1WriteData(req1WriteData), .req1Ack(req1Ack),
      .rsp1Valid(rsp1Valid), .rsp1Data(rsp1Data),
      .wrDoneValid(wrDoneValid), .wrDoneSerial(wrDoneSerial),
      .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
      .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
      .memAccessBusy(memAccessBusy),
      .memReadDataReady(memReadDataReady), .memReadData(memReadData),
      .memReadSerial(memReadSerial),
      .memWriteRespValid(memWriteRespValid), .memWriteRespSerial(memWriteRespSerial),
      .routeError(routeError)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      req0Valid = 0; req0Addr = '0;
      req1Valid = 0; req1Write = 0; req1Addr = '0; req1WriteData = '0;
      memAccessBusy = 0; memReadDataReady = 0; memReadData = '0; memReadSerial = '0;
      memWriteRespValid = 0; memWriteRespSerial = '0;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic cyc();
      @(negedge clk);
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1;
      req0Valid = 1; req0Addr = 32'h10;
      @(negedge clk);
      #1;
      check("rst_ack0", 128'(req0Ack), 128'(0));
      check("rst_re", 128'(memAccessRE), 128'(0));
      check("rst_err", 128'(routeError), 128'(0));
      @(negedge clk);
      idle();
      rst = 0;
   endtask

   task automatic respond(input logic [3:0] ser, input logic [127:0] dat, input bit port);
      cyc();
      memReadDataReady = 1; memReadSerial = ser; memReadData = dat;
      #1;
      check("rsp0_vld", 128'(rsp0Valid), 128'(!port));
      check("rsp1_vld", 128'(rsp1Valid), 128'(port));
      check("rsp_dat", port ? rsp1Data : rsp0Data, dat);
   endtask

   initial begin
      rst = 1;
      idle();

      // single read
      do_reset();
      cyc();
      req0Valid = 1; req0Addr = 32'h100;
      #1;
      check("t1_ack0", 128'(req0Ack), 128'(1));
      check("t1_re", 128'(memAccessRE), 128'(1));
      check("t1_we", 128'(memAccessWE), 128'(0));
      check("t1_addr", 128'(memAccessAddr), 128'(32'h100));
      respond(4'd0, {16{8'hA5}}, 1'b0);

      // contention: memory accepts every third cycle, grants must alternate from port 0
      do_reset();
      for (int g = 0; g < 4; g++) begin
         for (int b = 0; b < 3; b++) begin
            cyc();
            req0Valid = 1; req0Addr = 32'h200;
            req1Valid = 1; req1Addr = 32'h300;
            memAccessBusy = (b != 2);
            #1;
            if (b == 0) begin
               check("t2_busy_ack0", 128'(req0Ack), 128'(0));
               check("t2_busy_ack1", 128'(req1Ack), 128'(0));
            end
            if (b == 2) begin
               check("t2_ack0", 128'(req0Ack), 128'(g % 2 == 0));
               check("t2_ack1", 128'(req1Ack), 128'(g % 2 == 1));
               check("t2_addr", 128'(memAccessAddr), 128'((g % 2 == 0) ? 32'h200 : 32'h300));
            end
         end
         if (g % 2 == 1) begin
            respond(4'(g - 1), 128'(32'hD000 + g - 1), 1'b0);
            respond(4'(g), 128'(32'hD000 + g), 1'b1);
         end
      end

      // busy stall on a write
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc();
         req1Valid = 1; req1Write = 1; req1Addr = 32'h400; req1WriteData = 128'h1234_5678_9ABC;
         memAccessBusy = 1;
         #1;
         check("t3_stall_ack", 128'(req1Ack), 128'(0));
         check("t3_stall_we", 128'(memAccessWE), 128'(1));
         check("t3_stall_addr", 128'(memAccessAddr), 128'(32'h400));
         check("t3_stall_dat", memAccessWriteData, 128'h1234_5678_9ABC);
      end
      cyc();
      req1Valid = 1; req1Write = 1; req1Addr = 32'h400; req1WriteData = 128'h1234_5678_9ABC;
      #1;
      check("t3_ack", 128'(req1Ack), 128'(1));
      check("t3_re", 128'(memAccessRE), 128'(0));
      cyc();
      memWriteRespValid = 1; memWriteRespSerial = 4'd0;
      #1;
      check("t3_ack_pulse", 128'(req1Ack), 128'(0));
      check("t3_wrdone", 128'(wrDoneValid), 128'(1));
      check("t3_wrser", 128'(wrDoneSerial), 128'(0));

      // outstanding limit of 2
      do_reset();
      for (int i = 0; i < 2; i++) begin
         cyc();
         req0Valid = 1; req0Addr = 32'h500 + 32'(i);
         #1;
         check("t4_fill_ack", 128'(req0Ack), 128'(1));
      end
      cyc();
      req0Valid = 1; req0Addr = 32'h600;
      req1Valid = 1; req1Write = 1; req1Addr = 32'h700; req1WriteData = 128'hBEEF;
      #1;
      check("t4_blk_ack0", 128'(req0Ack), 128'(0));
      check("t4_wr_ack1", 128'(req1Ack), 128'(1));
      check("t4_wr_we", 128'(memAccessWE), 128'(1));
      check("t4_wr_re", 128'(memAccessRE), 128'(0));
      cyc();
      req0Valid = 1; req0Addr = 32'h600;
      #1;
      check("t4_blk_re", 128'(memAccessRE), 128'(0));
      cyc();
      req0Valid = 1; req0Addr = 32'h600;
      memReadDataReady = 1; memReadSerial = 4'd0; memReadData = 128'h77;
      #1;
      check("t4_free_rsp", 128'(rsp0Valid), 128'(1));
      check("t4_free_ack", 128'(req0Ack), 128'(0));
      cyc();
      req0Valid = 1; req0Addr = 32'h600;
      #1;
      check("t4_late_ack", 128'(req0Ack), 128'(1));

      // simultaneous accept and response at count 1 keeps the count at 1
      do_reset();
      cyc();
      req0Valid = 1; req0Addr = 32'h800;
      #1;
      check("t6_first", 128'(req0Ack), 128'(1));
      cyc();
      req0Valid = 1; req0Addr = 32'h810;
      memReadDataReady = 1; memReadSerial = 4'd0; memReadData = 128'h5;
      #1;
      check("t6_both_ack", 128'(req0Ack), 128'(1));
      check("t6_both_rsp", 128'(rsp0Valid), 128'(1));
      cyc();
      req1Valid = 1; req1Addr = 32'h820;
      #1;
      check("t6_second", 128'(req1Ack), 128'(1));
      cyc();
      req0Valid = 1; req0Addr = 32'h830;
      #1;
      check("t6_full_re", 128'(memAccessRE), 128'(0));

      // serial wrap with alternating issuers, then a stray response
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (i % 2 == 0) begin
            req0Valid = 1; req0Addr = 32'h900 + 32'(i);
         end else begin
            req1Valid = 1; req1Addr = 32'h900 + 32'(i);
         end
         #1;
         check("t5_ack", 128'((i % 2 == 0) ? req0Ack : req1Ack), 128'(1));
         respond(4'(i % 16), {4{32'hC0DE0000 + 32'(i)}}, 1'(i % 2));
      end
      check("t5_err_clean", 128'(routeError), 128'(0));
      cyc();
      memReadDataReady = 1; memReadSerial = 4'd5; memReadData = 128'h99;
      #1;
      check("t5_stray_rsp0", 128'(rsp0Valid), 128'(0));
      check("t5_stray_rsp1", 128'(rsp1Valid), 128'(0));
      cyc();
      cyc();
      #1;
      check("t5_err_set", 128'(routeError), 128'(1));
      cyc();
      #1;
      check("t5_err_sticky", 128'(routeError), 128'(1));
      do_reset();
      #1;
      check("t5_err_clr", 128'(routeError), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
